// File: rtl/regfile_arb_pkg.sv
// Shared constants and helpers for the register-file write-port arbiter.
package regfile_arb_pkg;

    localparam int         REG_ZERO           = 0;
    localparam logic [7:0] DROP_CNT_MAX       = 8'd255;
    localparam int         DEFAULT_DATA_WIDTH = 32;
    localparam int         DEFAULT_ADDR_WIDTH = 5;

    // Low bit of requester idx's field inside a flattened request bus.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first valid requester at or above rr_ptr,
// wrapping to the lowest index when none is found above it.
module rr_priority_picker #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  valid,
    input  logic [ID_WIDTH-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] grant_id
);

    logic w_found;

    always_comb begin
        // NOTE: every output gets a default first so no path through the block infers a latch.
        grant    = '0;
        grant_id = '0;
        w_found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && valid[i] && (i >= int'(rr_ptr))) begin
                grant[i] = 1'b1;
                grant_id = ID_WIDTH'(i);
                w_found  = 1'b1;
            end
        end
        // Wrap-around pass covers requesters below the pointer.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && valid[i]) begin
                grant[i] = 1'b1;
                grant_id = ID_WIDTH'(i);
                w_found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port; one
// registered write per cycle, register-0 writes accepted but suppressed.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          stall,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          wr_enable,
    output logic [ADDR_WIDTH-1:0]         wr_addr,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic [7:0]                    drop_count
);

    logic [ID_WIDTH-1:0]   r_rr_ptr;
    logic                  r_wr_enable;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [ID_WIDTH-1:0]   r_grant_id;
    logic [7:0]            r_drop_count;

    logic [NUM_REQ-1:0]    w_pick_grant;
    logic [ID_WIDTH-1:0]   w_pick_id;
    logic [NUM_REQ-1:0]    w_ready;
    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_acc_addr;
    logic [DATA_WIDTH-1:0] w_acc_data;
    logic                  w_acc_is_zero;

    rr_priority_picker #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_picker (
        .valid    (req_valid),
        .rr_ptr   (r_rr_ptr),
        .grant    (w_pick_grant),
        .grant_id (w_pick_id)
    );

    assign w_ready   = (reset || stall) ? '0 : w_pick_grant;
    assign w_accept  = |w_ready;
    assign req_ready = w_ready;

    // One-hot AND-OR mux of the winning requester's address and data.
    always_comb begin
        w_acc_addr = '0;
        w_acc_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick_grant[i]) begin
                w_acc_addr = w_acc_addr | req_addr[slice_lo(i, ADDR_WIDTH) +: ADDR_WIDTH];
                w_acc_data = w_acc_data | req_data[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH];
            end
        end
    end

    assign w_acc_is_zero = (w_acc_addr == ADDR_WIDTH'(REG_ZERO));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr     <= '0;
            r_wr_enable  <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_grant_id   <= '0;
            r_drop_count <= '0;
        end else begin
            r_wr_enable <= 1'b0;
            if (w_accept) begin
                r_rr_ptr    <= (w_pick_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_pick_id + ID_WIDTH'(1);
                r_wr_enable <= !w_acc_is_zero;
                r_wr_addr   <= w_acc_addr;
                r_wr_data   <= w_acc_data;
                r_grant_id  <= w_pick_id;
                if (w_acc_is_zero && (r_drop_count != DROP_CNT_MAX)) begin
                    r_drop_count <= r_drop_count + 8'd1;
                end
            end
        end
    end

    assign wr_enable  = r_wr_enable;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign grant_id   = r_grant_id;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (NUM_REQ=4).
module tb_regfile_write_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int ID_WIDTH   = 2;

    logic                          clk;
    logic                          reset;
    logic                          stall;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          wr_enable;
    logic [ADDR_WIDTH-1:0]         wr_addr;
    logic [DATA_WIDTH-1:0]         wr_data;
    logic [ID_WIDTH-1:0]           grant_id;
    logic [7:0]                    drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_write_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ID_WIDTH   (ID_WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .wr_enable  (wr_enable),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .grant_id   (grant_id),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [ADDR_WIDTH-1:0] addr,
                           input logic [DATA_WIDTH-1:0] data);
        req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH] = addr;
        req_data[idx*DATA_WIDTH +: DATA_WIDTH] = data;
    endtask

    task automatic check_wr(input string tag, input logic en, input logic [ADDR_WIDTH-1:0] addr,
                            input logic [DATA_WIDTH-1:0] data, input logic [ID_WIDTH-1:0] id);
        check({tag, "_en"},   32'(wr_enable), 32'(en));
        check({tag, "_addr"}, 32'(wr_addr),   32'(addr));
        check({tag, "_data"}, 32'(wr_data),   32'(data));
        check({tag, "_id"},   32'(grant_id),  32'(id));
    endtask

    initial begin
        reset     = 1'b1;
        stall     = 1'b0;
        req_valid = 4'b1111;
        req_addr  = '0;
        req_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, ADDR_WIDTH'(i + 3), DATA_WIDTH'(i + 11));

        // Reset with every requester valid: nothing may be accepted.
        for (int c = 0; c < 2; c++) begin
            #1;
            check("rst_ready", 32'(req_ready), 32'd0);
            tick();
        end
        check_wr("rst_out", 1'b0, 5'd0, 32'd0, 2'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        reset     = 1'b0;
        req_valid = 4'b0000;
        #1;
        check("idle_ready", 32'(req_ready), 32'd0);
        tick();
        check_wr("idle_out", 1'b0, 5'd0, 32'd0, 2'd0);
        check("idle_drop", 32'(drop_count), 32'd0);

        // Single write from requester 2.
        set_req(2, 5'd7, 32'd88);
        req_valid = 4'b0100;
        #1;
        check("single_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = 4'b0000;
        check_wr("single_wr", 1'b1, 5'd7, 32'd88, 2'd2);
        tick();
        check_wr("single_hold", 1'b0, 5'd7, 32'd88, 2'd2);

        // Fresh pointer, then all four continuously valid.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, ADDR_WIDTH'(i + 1), DATA_WIDTH'(100 + i));
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
            tick();
            check_wr("rr_wr", 1'b1, ADDR_WIDTH'((k % 4) + 1), DATA_WIDTH'(100 + (k % 4)),
                     ID_WIDTH'(k % 4));
        end
        req_valid = 4'b0000;

        // Register-0 write from requester 1 (pointer now at 1).
        set_req(1, 5'd0, 32'd42);
        req_valid = 4'b0010;
        #1;
        check("r0_ready", 32'(req_ready), 32'b0010);
        tick();
        check_wr("r0_wr", 1'b0, 5'd0, 32'd42, 2'd1);
        check("r0_drop", 32'(drop_count), 32'd1);
        for (int k = 1; k <= 256; k++) begin
            tick();
            if (k == 253) check("r0_drop_254", 32'(drop_count), 32'd254);
        end
        check("r0_drop_sat", 32'(drop_count), 32'd255);
        check("r0_sat_en", 32'(wr_enable), 32'd0);
        req_valid = 4'b0000;
        tick();
        check("r0_drop_hold", 32'(drop_count), 32'd255);

        // Stall: pointer at 2, so requester 3 wins just before the stall.
        set_req(0, 5'd4, 32'd200);
        set_req(3, 5'd9, 32'd300);
        req_valid = 4'b1001;
        #1;
        check("pre_stall_ready", 32'(req_ready), 32'b1000);
        tick();
        set_req(3, 5'd10, 32'd301);
        stall = 1'b1;
        check_wr("stall_first", 1'b1, 5'd9, 32'd300, 2'd3);
        for (int s = 0; s < 3; s++) begin
            #1;
            check("stall_ready", 32'(req_ready), 32'd0);
            tick();
            check("stall_en", 32'(wr_enable), 32'd0);
        end
        stall = 1'b0;
        #1;
        check("unstall_ready0", 32'(req_ready), 32'b0001);
        tick();
        req_valid = 4'b1000;
        check_wr("unstall_wr0", 1'b1, 5'd4, 32'd200, 2'd0);
        #1;
        check("unstall_ready3", 32'(req_ready), 32'b1000);
        tick();
        req_valid = 4'b0000;
        check_wr("unstall_wr3", 1'b1, 5'd10, 32'd301, 2'd3);

        // Reset in the cycle after an acceptance loses that write.
        set_req(1, 5'd5, 32'd651);
        req_valid = 4'b0010;
        #1;
        check("mid_ready", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b0000;
        reset     = 1'b1;
        check("mid_pre_en", 32'(wr_enable), 32'd1);
        #1;
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        tick();
        check_wr("mid_rst", 1'b0, 5'd0, 32'd0, 2'd0);
        reset = 1'b0;
        set_req(0, 5'd6, 32'd600);
        set_req(1, 5'd8, 32'd700);
        req_valid = 4'b0011;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'b0001);
        tick();
        req_valid = 4'b0000;
        check_wr("post_rst_wr", 1'b1, 5'd6, 32'd600, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32 x 32-bit register file between NUM_REQ requesters (e.g. ALU writeback, load writeback, link-register write, debug/test port).
- Round-robin arbitration, one write per cycle, valid/ready handshake per requester.
- Registered write outputs drive the register file's write decoder; the decoder fans out to the per-register enable inputs.
- Writes to register 0 are accepted but suppressed.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 32, write data width
- ADDR_WIDTH, 5, register index width
- ID_WIDTH, 2, requester id width; must equal clog2(NUM_REQ)

Ports:
- clk  input  1  rising-edge clock; only clock in the block
- reset  input  1  synchronous, active-high reset
- stall  input  1  blocks all grants this cycle
- req_valid  input  NUM_REQ  per-requester write request
- req_addr  input  NUM_REQ*ADDR_WIDTH  flattened target index; requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_data  input  NUM_REQ*DATA_WIDTH  flattened write data, same packing
- req_ready  output  NUM_REQ  one-hot or zero; accept strobe (combinational)
- wr_enable  output  1  registered write strobe to register file
- wr_addr  output  ADDR_WIDTH  registered write index
- wr_data  output  DATA_WIDTH  registered write data
- grant_id  output  ID_WIDTH  registered id of last accepted requester
- drop_count  output  8  saturating count of suppressed register-0 writes

Behaviour:
- Handshake: requester i is accepted in a cycle where req_valid[i] and req_ready[i] are both 1.
  - Requesters hold valid, addr and data stable until accepted.
  - req_ready never depends on req_ready itself.
- Arbitration (combinational):
  - Search starts at rr_ptr and proceeds upward, wrapping modulo NUM_REQ; the first valid requester wins.
  - At most one req_ready bit is high.
  - All req_ready bits are 0 when stall=1, when reset=1, or when no request is valid.
- rr_ptr update:
  - On acceptance of requester g: rr_ptr <= (g+1) mod NUM_REQ; with NUM_REQ=4 and g=3, rr_ptr becomes 0.
  - With no acceptance, rr_ptr holds.
  - Fairness: a continuously valid requester is accepted within NUM_REQ cycles of non-stalled operation.
- Output stage, latency 1:
  - Acceptance in cycle N produces wr_addr, wr_data and grant_id in cycle N+1.
  - wr_enable in N+1 is 1 if the accepted addr != 0, else 0.
  - A register-0 write increments drop_count, which saturates at 255.
  - No acceptance in N: wr_enable=0 in N+1; wr_addr, wr_data and grant_id hold their values.
- stall:
  - Affects acceptance only.
  - A write already registered (accepted in the previous cycle) still presents wr_enable=1 during the stall cycle.
- Back-to-back writes to the same index from different requesters are issued in acceptance order; the last write wins. No merging or reordering.
- Reset (synchronous; dominates every other input):
  - wr_enable=0, wr_addr=0, wr_data=0, grant_id=0, drop_count=0, rr_ptr=0.
  - A request visible during reset is not accepted.
  - Reset asserted in the cycle after an acceptance clears wr_enable. That write is lost; the requester already saw ready and must not retry.
- Out-of-range: requests are never granted to indices >= NUM_REQ. The unused ID space is ignored.

Decomposition:
- Package regfile_arb_pkg:
  - Constants REG_ZERO=0 and DROP_CNT_MAX=255.
  - Default widths (DATA_WIDTH=32, ADDR_WIDTH=5).
  - Helper function for flattened slice offsets.
- One sub-module, rr_priority_picker: purely combinational.
  - Inputs: valid vector, rr_ptr.
  - Outputs: one-hot grant and encoded id.
- The arbiter instantiates the picker and holds rr_ptr, the output registers and drop_count.

Test Plan:
- Reset/idle: hold reset=1 for 2 cycles with req_valid=4'b1111, then release with req_valid=0. Required: req_ready=0 throughout; wr_enable=0, wr_addr=0, wr_data=0, grant_id=0, drop_count=0.
- Single write: requester 2 valid with addr=7, data=88. Required: req_ready=4'b0100 that cycle; next cycle wr_enable=1, wr_addr=7, wr_data=88, grant_id=2; the cycle after, wr_enable=0 with addr/data held.
- Round-robin: all four valid continuously, addr=i+1, data=100+i. Required grant order 0,1,2,3,0; wr_data sequence 100,101,102,103,100; one accept per cycle.
- Register 0: requester 1 writes addr=0, data=42. Required: accepted; next cycle wr_enable=0, grant_id=1, drop_count=1.
  - Then 256 further addr-0 writes: drop_count stays at 255.
- Stall: requesters 0 and 3 valid, stall=1 for 3 cycles, then stall=0. Required: no ready during the stall, rr_ptr unchanged; after release, requester 0 is accepted, then requester 3.
  - An acceptance in the cycle just before the stall still gives wr_enable=1 during the first stall cycle.
- Reset mid-operation: accept requester 1 (addr=5, data=651), then reset=1 in the next cycle. Required: wr_enable=0, wr_addr=0, wr_data=0 after that edge; rr_ptr=0, so requester 0 wins first after release.
